// File: rtl/run_detect_sched.sv
// Shares one run detector among N_CH serial streams.
// A round-robin arbiter grants one bit per cycle, which is scored against that channel's saved context.
module run_detect_sched #(
  parameter int N_CH    = 4,
  parameter int RUN_LEN = 3,
  parameter int CNT_W   = 2,
  parameter int CH_W    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [N_CH-1:0] req_valid,
  input  logic [N_CH-1:0] req_bit,
  output logic [N_CH-1:0] req_ready,
  input  logic [N_CH-1:0] ch_clear,
  output logic            out_valid,
  output logic [CH_W-1:0] out_ch,
  output logic            out_bit,
  output logic            out_y,
  input  logic            out_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(RUN_LEN);
  localparam logic [CH_W:0]    N_CH_EXT = (CH_W+1)'(N_CH);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_CH - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CH_W-1:0]  ptr;
  logic [CH_W-1:0]  ptr_nxt;
  logic [N_CH-1:0]  ctx_last;
  logic [CNT_W-1:0] ctx_cnt [N_CH];

  logic             grant_en;
  logic             xfer;
  logic [N_CH-1:0]  gnt;
  logic [CH_W-1:0]  gnt_idx;
  logic             gnt_bit;
  logic             cur_last;
  logic [CNT_W-1:0] cur_cnt;
  logic [CNT_W-1:0] new_cnt;
  logic             new_y;

  // Grants only flow in RUN while the output register can take a new result.
  assign grant_en  = (state == RUN) && enable && !reset && (!out_valid || out_ready);
  assign req_ready = gnt;

  // Round-robin search starting at ptr, first requesting channel wins.
  always_comb begin
    logic [CH_W:0]   sum;
    logic [CH_W-1:0] idx;
    logic            hit;
    gnt     = '0;
    gnt_idx = '0;
    xfer    = 1'b0;
    sum     = '0;
    idx     = '0;
    hit     = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      sum          = {1'b0, ptr} + (CH_W+1)'(i);
      sum          = (sum >= N_CH_EXT) ? (sum - N_CH_EXT) : sum;
      idx          = sum[CH_W-1:0];
      hit          = grant_en && !xfer && req_valid[idx];
      gnt[idx]     = hit;
      gnt_idx      = hit ? idx : gnt_idx;
      xfer         = xfer | hit;
    end
  end

  // A same-cycle clear makes the granted bit the first of a fresh run.
  always_comb begin
    gnt_bit  = req_bit[gnt_idx];
    cur_last = ctx_last[gnt_idx];
    cur_cnt  = ch_clear[gnt_idx] ? '0 : ctx_cnt[gnt_idx];
    if ((cur_cnt == '0) || (gnt_bit != cur_last)) begin
      new_cnt = CNT_W'(1);
    end else if (cur_cnt >= RUN_MAX) begin
      new_cnt = RUN_MAX;
    end else begin
      new_cnt = cur_cnt + CNT_W'(1);
    end
    new_y = (new_cnt == RUN_MAX);
  end

  // Pointer advances past the winner only when a bit is actually taken.
  always_comb begin
    if (xfer) begin
      ptr_nxt = (gnt_idx == LAST_CH) ? '0 : (gnt_idx + CH_W'(1));
    end else begin
      ptr_nxt = ptr;
    end
  end

  // Control FSM; dropping enable wins over a stall so IDLE can drain the output.
  always_comb begin
    case (state)
      IDLE: state_nxt = enable ? RUN : IDLE;
      RUN: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (out_valid && !out_ready) begin
          state_nxt = HOLD;
        end else begin
          state_nxt = RUN;
        end
      end
      HOLD:    state_nxt = out_ready ? RUN : HOLD;
      default: state_nxt = IDLE;
    endcase
  end

  // State and arbitration pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Per-channel run contexts.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctx_last <= '0;
      for (int c = 0; c < N_CH; c++) begin
        ctx_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (xfer && (gnt_idx == CH_W'(c))) begin
          ctx_last[c] <= gnt_bit;
          ctx_cnt[c]  <= new_cnt;
        end else if (ch_clear[c]) begin
          ctx_last[c] <= 1'b0;
          ctx_cnt[c]  <= '0;
        end else begin
          ctx_last[c] <= ctx_last[c];
          ctx_cnt[c]  <= ctx_cnt[c];
        end
      end
    end
  end

  // Result register, one cycle behind the transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_bit   <= 1'b0;
      out_y     <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_ch    <= gnt_idx;
      out_bit   <= gnt_bit;
      out_y     <= new_y;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_run_detect_sched.sv
// Table-driven bench for run_detect_sched: each vector gives inputs and the expected grant.
// Expected results are queued on each transfer and compared when the DUT presents them.
module tb_run_detect_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] req_valid;
  logic [3:0] req_bit;
  logic [3:0] req_ready;
  logic [3:0] ch_clear;
  logic       out_valid;
  logic [1:0] out_ch;
  logic       out_bit;
  logic       out_y;
  logic       out_ready;

  always #5 clk = ~clk;

  run_detect_sched dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .req_valid (req_valid),
    .req_bit   (req_bit),
    .req_ready (req_ready),
    .ch_clear  (ch_clear),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_bit   (out_bit),
    .out_y     (out_y),
    .out_ready (out_ready)
  );

  typedef struct {
    logic       en;
    logic       rst;
    logic [3:0] vld;
    logic [3:0] bits;
    logic [3:0] clr;
    logic       ordy;
    logic [3:0] gnt;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] sb[$];
  int         m_cnt[4];
  logic       m_last[4];
  int         checks = 0;
  int         failures = 0;
  int         vec_no = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0h exp=%0h", name, vec_no, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic rst, input logic [3:0] vld, input logic [3:0] bits,
                     input logic [3:0] clr, input logic ordy, input logic [3:0] gnt);
    vec_t v;
    v.en = en; v.rst = rst; v.vld = vld; v.bits = bits; v.clr = clr; v.ordy = ordy; v.gnt = gnt;
    tbl.push_back(v);
  endtask

  // Drive one cycle, check grant and output against the queue, then update the context model.
  task automatic apply(input vec_t v);
    logic [3:0] front;
    int         g;
    logic       b;
    logic       y;
    @(posedge clk);
    #1;
    enable = v.en; reset = v.rst; req_valid = v.vld; req_bit = v.bits;
    ch_clear = v.clr; out_ready = v.ordy;
    @(negedge clk);
    check("grant", 8'(req_ready), 8'(v.gnt));
    check("out_valid", 8'(out_valid), 8'(sb.size() != 0));
    if (sb.size() != 0) begin
      front = sb[0];
      check("out_ch", 8'(out_ch), 8'(front[3:2]));
      check("out_bit", 8'(out_bit), 8'(front[1]));
      check("out_y", 8'(out_y), 8'(front[0]));
      if (v.ordy) void'(sb.pop_front());
    end
    if (v.rst) begin
      sb.delete();
      for (int c = 0; c < 4; c++) begin m_cnt[c] = 0; m_last[c] = 1'b0; end
    end else begin
      for (int c = 0; c < 4; c++) if (v.clr[c]) begin m_cnt[c] = 0; m_last[c] = 1'b0; end
      g = -1;
      for (int c = 0; c < 4; c++) if (v.gnt[c]) g = c;
      if (g >= 0) begin
        b = v.bits[g];
        if (m_cnt[g] == 0 || b != m_last[g]) begin
          m_cnt[g] = 1; m_last[g] = b;
        end else if (m_cnt[g] < 3) begin
          m_cnt[g] = m_cnt[g] + 1;
        end
        y = (m_cnt[g] == 3);
        sb.push_back({2'(g), b, y});
      end
    end
    vec_no++;
  endtask

  task automatic step(input logic en, input logic rst, input logic [3:0] vld, input logic [3:0] bits,
                      input logic [3:0] clr, input logic ordy, input logic [3:0] gnt);
    vec_t v;
    v.en = en; v.rst = rst; v.vld = vld; v.bits = bits; v.clr = clr; v.ordy = ordy; v.gnt = gnt;
    apply(v);
  endtask

  initial begin
    logic [3:0] one_hot;
    reset = 1'b1; enable = 1'b0; req_valid = '0; req_bit = '0; ch_clear = '0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin m_cnt[c] = 0; m_last[c] = 1'b0; end

    // ch0 alone, bits 1,1,1,1 (first vector is the IDLE->RUN cycle)
    add(1, 0, 4'b0001, 4'b0001, 4'b0000, 1, 4'b0000);
    for (int k = 0; k < 4; k++) add(1, 0, 4'b0001, 4'b0001, 4'b0000, 1, 4'b0001);
    // clear with transfer, then 1,1,0,0,0
    add(1, 0, 4'b0001, 4'b0001, 4'b0001, 1, 4'b0001);
    add(1, 0, 4'b0001, 4'b0001, 4'b0000, 1, 4'b0001);
    for (int k = 0; k < 3; k++) add(1, 0, 4'b0001, 4'b0000, 4'b0000, 1, 4'b0001);
    // all channels requesting: rotation from ch1
    for (int k = 0; k < 12; k++) begin
      one_hot = 4'b0001 << ((k + 1) % 4);
      add(1, 0, 4'b1111, 4'b1111, 4'b0000, 1, one_hot);
    end
    // stall three cycles, release, resume at next channel
    for (int k = 0; k < 3; k++) add(1, 0, 4'b1111, 4'b1111, 4'b0000, 0, 4'b0000);
    add(1, 0, 4'b1111, 4'b1111, 4'b0000, 1, 4'b0000);
    add(1, 0, 4'b1111, 4'b1111, 4'b0000, 1, 4'b0010);
    // ch1: clear, 1,1, clear beside ch3 transfer, 1,1,1
    add(1, 0, 4'b0000, 4'b0000, 4'b0010, 1, 4'b0000);
    add(1, 0, 4'b0010, 4'b0010, 4'b0000, 1, 4'b0010);
    add(1, 0, 4'b0010, 4'b0010, 4'b0000, 1, 4'b0010);
    add(1, 0, 4'b1000, 4'b1000, 4'b0010, 1, 4'b1000);
    for (int k = 0; k < 3; k++) add(1, 0, 4'b0010, 4'b0010, 4'b0000, 1, 4'b0010);
    // ch2 to count 2 with zeros, then reset while its result is pending
    add(1, 0, 4'b0100, 4'b0000, 4'b0000, 1, 4'b0100);
    add(1, 0, 4'b0100, 4'b0000, 4'b0000, 1, 4'b0100);
    add(1, 1, 4'b0100, 4'b0000, 4'b0000, 0, 4'b0000);
    add(1, 0, 4'b0101, 4'b0100, 4'b0000, 1, 4'b0000);
    add(1, 0, 4'b0101, 4'b0100, 4'b0000, 1, 4'b0001);
    add(1, 0, 4'b0101, 4'b0100, 4'b0000, 1, 4'b0100);
    add(1, 0, 4'b0100, 4'b0100, 4'b0000, 1, 4'b0100);
    add(1, 0, 4'b0100, 4'b0100, 4'b0000, 1, 4'b0100);
    // enable drops with a result in flight
    add(0, 0, 4'b0100, 4'b0100, 4'b0000, 0, 4'b0000);
    add(0, 0, 4'b0100, 4'b0100, 4'b0000, 0, 4'b0000);
    add(0, 0, 4'b0100, 4'b0100, 4'b0000, 1, 4'b0000);
    add(0, 0, 4'b0100, 4'b0100, 4'b0000, 1, 4'b0000);
    add(1, 0, 4'b0100, 4'b0100, 4'b0000, 1, 4'b0000);
    add(1, 0, 4'b0100, 4'b0100, 4'b0000, 1, 4'b0100);
    add(1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 8'(out_valid), 8'd0);
    check("rst_out_ch", 8'(out_ch), 8'd0);
    check("rst_out_bit", 8'(out_bit), 8'd0);
    check("rst_out_y", 8'(out_y), 8'd0);
    check("rst_req_ready", 8'(req_ready), 8'd0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // reset while in HOLD drops the frozen result; first grant afterwards goes to the lowest channel
    step(1, 0, 4'b1000, 4'b1000, 4'b0000, 0, 4'b1000);
    step(1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000);
    step(1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000);
    step(1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000);
    step(0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000);
    step(1, 0, 4'b0010, 4'b0010, 4'b0000, 1, 4'b0000);
    step(1, 0, 4'b0010, 4'b0010, 4'b0000, 1, 4'b0010);
    step(1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000);
    step(1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
